// File: rtl/vga_frame_reader.sv
// vga_frame_reader: read side of the camera->SDRAM frame path.
// Generates SVGA timing (800x600@60 by default) on the pixel clock, strobes one
// pixel pair per active pixel out of the two SDRAM read FIFOs, unpacks the split
// 30-bit RGB word onto the 8-bit DAC pins and pulses FRAME_START once per frame
// so the FIFO read pointers can be reloaded during vertical blanking.
//
// Ports:
//   CLK          pixel clock, also the FIFO read clock
//   RESET_N      asynchronous active-low reset
//   RD_DATA1     FIFO 1 word {1'b0, G[9:5], B[9:0]}
//   RD_DATA2     FIFO 2 word {1'b0, G[4:0], R[9:0]}
//   READ         shared FIFO read strobe
//   FRAME_START  one-cycle pulse at the start of vertical sync
//   H_POS/V_POS  coordinate of the pixel currently on the pins
//   VGA_R/G/B    colour outputs
//   VGA_HS/VS    sync outputs, active level SYNC_POL
//   VGA_BLANK_N  low outside the active region
//   VGA_SYNC_N   tied low (no sync-on-green)
//
// Optional feature: define CROSSHAIR_EN to overlay a green aiming crosshair on
// the centre column and centre row of the active region.
module vga_frame_reader #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FRONT  = 40,
    parameter int unsigned H_SYNC   = 128,
    parameter int unsigned H_BACK   = 88,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned V_FRONT  = 1,
    parameter int unsigned V_SYNC   = 4,
    parameter int unsigned V_BACK   = 23,
    parameter bit          SYNC_POL = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [15:0] RD_DATA1,
    input  logic [15:0] RD_DATA2,
    output logic        READ,
    output logic        FRAME_START,
    output logic [10:0] H_POS,
    output logic [9:0]  V_POS,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N
);

    localparam int unsigned HW      = 11;
    localparam int unsigned VW      = 10;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [HW-1:0] s1_h;
    logic [VW-1:0] s1_v;
    logic          s1_hs;
    logic          s1_vs;

    logic          active_c;
    logic          hs_c;
    logic          vs_c;
    logic          frame_c;
    logic [9:0]    r10_c;
    logic [9:0]    g10_c;
    logic [9:0]    b10_c;
    logic [7:0]    pix_r_c;
    logic [7:0]    pix_g_c;
    logic [7:0]    pix_b_c;
    logic          unused_bits;

    // Raster counters: h wraps every line, v advances (and wraps) on the h wrap.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == HW'(H_TOTAL - 1)) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    // Region decode on the raw counter values.
    always_comb begin
        active_c = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
        hs_c     = (h_cnt >= HW'(H_ACTIVE + H_FRONT)) &&
                   (h_cnt <  HW'(H_ACTIVE + H_FRONT + H_SYNC));
        vs_c     = (v_cnt >= VW'(V_ACTIVE + V_FRONT)) &&
                   (v_cnt <  VW'(V_ACTIVE + V_FRONT + V_SYNC));
        frame_c  = (v_cnt == VW'(V_ACTIVE + V_FRONT)) && (h_cnt == '0);
    end

    // Stage 1: READ marks the active cycles; FIFO data arrives for the next edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            s1_h        <= '0;
            s1_v        <= '0;
            s1_hs       <= 1'b0;
            s1_vs       <= 1'b0;
            READ        <= 1'b0;
            FRAME_START <= 1'b0;
        end else begin
            s1_h        <= h_cnt;
            s1_v        <= v_cnt;
            s1_hs       <= hs_c;
            s1_vs       <= vs_c;
            READ        <= active_c;
            FRAME_START <= frame_c;
        end
    end

    // Unpack the split 30-bit word; the low two bits of each colour are dropped.
    always_comb begin
        r10_c = RD_DATA2[9:0];
        g10_c = {RD_DATA1[14:10], RD_DATA2[14:10]};
        b10_c = RD_DATA1[9:0];
    end

    assign unused_bits = ^{RD_DATA1[15], RD_DATA2[15], r10_c[1:0], g10_c[1:0], b10_c[1:0]};

    // Pixel select: black in blanking, FIFO colour (or overlay) when active.
    always_comb begin
        pix_r_c = '0;
        pix_g_c = '0;
        pix_b_c = '0;
        if (READ) begin
            pix_r_c = r10_c[9:2];
            pix_g_c = g10_c[9:2];
            pix_b_c = b10_c[9:2];
        end
`ifdef CROSSHAIR_EN
        // Overlay replaces the FIFO word; the read still happens to keep the FIFO in step.
        if (READ && ((s1_h == HW'(H_ACTIVE / 2)) || (s1_v == VW'(V_ACTIVE / 2)))) begin
            pix_r_c = 8'h00;
            pix_g_c = 8'hFF;
            pix_b_c = 8'h00;
        end
`else
`endif
    end

    // Stage 2: every pin updates on the same edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            H_POS       <= '0;
            V_POS       <= '0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            VGA_HS      <= ~SYNC_POL;
            VGA_VS      <= ~SYNC_POL;
            VGA_BLANK_N <= 1'b0;
        end else begin
            H_POS       <= s1_h;
            V_POS       <= s1_v;
            VGA_R       <= pix_r_c;
            VGA_G       <= pix_g_c;
            VGA_B       <= pix_b_c;
            VGA_HS      <= s1_hs ? SYNC_POL : ~SYNC_POL;
            VGA_VS      <= s1_vs ? SYNC_POL : ~SYNC_POL;
            VGA_BLANK_N <= READ;
        end
    end

    assign VGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader: a reduced-geometry instance exercises whole frames,
// a default-geometry instance exercises real SVGA line timing. Both are compared
// every cycle against a raster model computed from the cycle count since reset.
`timescale 1ns/100ps
module tb_vga_frame_reader;

    // Reduced geometry: 28 cycles per line, 18 lines per frame.
    localparam int SH_A = 16, SH_F = 3, SH_S = 5, SH_B = 4;
    localparam int SV_A = 12, SV_F = 1, SV_S = 2, SV_B = 3;
    localparam int DH_A = 800, DH_F = 40, DH_S = 128, DH_B = 88;
    localparam int DV_A = 600, DV_F = 1, DV_S = 4, DV_B = 23;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [15:0] RD_DATA1 = '0;
    logic [15:0] RD_DATA2 = '0;

    logic        s_read, s_fs, s_hs, s_vs, s_blank, s_syncn;
    logic [10:0] s_hp;
    logic [9:0]  s_vp;
    logic [7:0]  s_r, s_g, s_b;
    logic        d_read, d_fs, d_hs, d_vs, d_blank, d_syncn;
    logic [10:0] d_hp;
    logic [9:0]  d_vp;
    logic [7:0]  d_r, d_g, d_b;

    int checks = 0;
    int errors = 0;
    int k = 0;
    logic [15:0] sd1 = '0, sd2 = '0;

    vga_frame_reader #(
        .H_ACTIVE(SH_A), .H_FRONT(SH_F), .H_SYNC(SH_S), .H_BACK(SH_B),
        .V_ACTIVE(SV_A), .V_FRONT(SV_F), .V_SYNC(SV_S), .V_BACK(SV_B),
        .SYNC_POL(1'b1)
    ) dut_s (
        .CLK(CLK), .RESET_N(RESET_N), .RD_DATA1(RD_DATA1), .RD_DATA2(RD_DATA2),
        .READ(s_read), .FRAME_START(s_fs), .H_POS(s_hp), .V_POS(s_vp),
        .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b), .VGA_HS(s_hs), .VGA_VS(s_vs),
        .VGA_BLANK_N(s_blank), .VGA_SYNC_N(s_syncn)
    );

    vga_frame_reader dut_d (
        .CLK(CLK), .RESET_N(RESET_N), .RD_DATA1(RD_DATA1), .RD_DATA2(RD_DATA2),
        .READ(d_read), .FRAME_START(d_fs), .H_POS(d_hp), .V_POS(d_vp),
        .VGA_R(d_r), .VGA_G(d_g), .VGA_B(d_b), .VGA_HS(d_hs), .VGA_VS(d_vs),
        .VGA_BLANK_N(d_blank), .VGA_SYNC_N(d_syncn)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int read, fs, hs, vs, blank, hp, vp, r, g, b;
    } exp_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at k=%0d: got %0d, expected %0d", name, k, act, exp);
        end
    endtask

    // Expected outputs in cycle kk after reset release; d1/d2 are the FIFO words
    // present at the edge that started this cycle.
    function automatic exp_t model(input int ha, hf, hs, hb, va, vf, vs, vb,
                                   input int kk, input int d1, input int d2);
        exp_t e;
        int ht, vt, h, v, q;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        e = '{default: 0};
        if (kk >= 1) begin
            q = kk - 1;
            h = q % ht;
            v = (q / ht) % vt;
            e.read = (h < ha && v < va) ? 1 : 0;
            e.fs   = (v == va + vf && h == 0) ? 1 : 0;
        end
        if (kk >= 2) begin
            q = kk - 2;
            h = q % ht;
            v = (q / ht) % vt;
            e.hp    = h;
            e.vp    = v;
            e.blank = (h < ha && v < va) ? 1 : 0;
            e.hs    = (h >= ha + hf && h < ha + hf + hs) ? 1 : 0;
            e.vs    = (v >= va + vf && v < va + vf + vs) ? 1 : 0;
            if (e.blank == 1) begin
                e.r = (d2 % 1024) / 4;
                e.g = ((((d1 / 1024) % 32) * 32) + ((d2 / 1024) % 32)) / 4;
                e.b = (d1 % 1024) / 4;
`ifdef CROSSHAIR_EN
                if (h == ha / 2 || v == va / 2) begin
                    e.r = 0;
                    e.g = 255;
                    e.b = 0;
                end
`endif
            end
        end
        return e;
    endfunction

    task automatic cmp_inst(input string t, input exp_t e,
                            input logic rd, fs, hs, vs, bl, sn,
                            input logic [10:0] hp, input logic [9:0] vp,
                            input logic [7:0] r, g, b);
        chk({t, ".READ"},        int'(rd), e.read);
        chk({t, ".FRAME_START"}, int'(fs), e.fs);
        chk({t, ".VGA_HS"},      int'(hs), e.hs);
        chk({t, ".VGA_VS"},      int'(vs), e.vs);
        chk({t, ".VGA_BLANK_N"}, int'(bl), e.blank);
        chk({t, ".VGA_SYNC_N"},  int'(sn), 0);
        chk({t, ".H_POS"},       int'(hp), e.hp);
        chk({t, ".V_POS"},       int'(vp), e.vp);
        chk({t, ".VGA_R"},       int'(r),  e.r);
        chk({t, ".VGA_G"},       int'(g),  e.g);
        chk({t, ".VGA_B"},       int'(b),  e.b);
    endtask

    // Cycle index since release, and the FIFO words sampled on each edge.
    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) k <= 0;
        else          k <= k + 1;
    end
    always @(posedge CLK) begin
        sd1 <= RD_DATA1;
        sd2 <= RD_DATA2;
    end

    // FIFO stand-in: random words, with two fixed patterns over an active stretch.
    always @(posedge CLK) begin
        #1;
        if (k >= 113 && k <= 118) begin
            RD_DATA1 = 16'h7FFF;
            RD_DATA2 = 16'h0000;
        end else if (k >= 119 && k <= 124) begin
            RD_DATA1 = 16'h0000;
            RD_DATA2 = 16'h7FFF;
        end else begin
            RD_DATA1 = 16'($urandom);
            RD_DATA2 = 16'($urandom);
        end
    end

    // Compare process plus literal pins on timing and unpacking.
    bit seen_fs = 0;
    bit hs_prev = 0, bl_prev = 0, hs_rise_ok = 0, bl_rise_ok = 0, hs_per_ok = 0;
    int hs_rise_k = 0, bl_rise_k = 0;

    always @(negedge CLK) begin
        exp_t es, ed;
        if (!RESET_N) begin
            es = '{default: 0};
            ed = '{default: 0};
            seen_fs = 0;
            hs_rise_ok = 0; bl_rise_ok = 0; hs_per_ok = 0;
            hs_prev = 0; bl_prev = 0;
        end else begin
            es = model(SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, k, int'(sd1), int'(sd2));
            ed = model(DH_A, DH_F, DH_S, DH_B, DV_A, DV_F, DV_S, DV_B, k, int'(sd1), int'(sd2));
        end
        cmp_inst("small", es, s_read, s_fs, s_hs, s_vs, s_blank, s_syncn, s_hp, s_vp, s_r, s_g, s_b);
        cmp_inst("svga",  ed, d_read, d_fs, d_hs, d_vs, d_blank, d_syncn, d_hp, d_vp, d_r, d_g, d_b);
        if (RESET_N) begin
            // Line 13 of the reduced raster starts at counter index 364.
            if (s_fs && !seen_fs) begin
                chk("first_frame_start_k", k, 365);
                seen_fs = 1;
            end
            if (es.blank == 1 && es.hp != SH_A / 2 && es.vp != SV_A / 2) begin
                if (sd1 == 16'h7FFF && sd2 == 16'h0000)
                    chk("unpack_a_rgb", int'({s_r, s_g, s_b}), 24'h00F8FF);
                if (sd1 == 16'h0000 && sd2 == 16'h7FFF)
                    chk("unpack_b_rgb", int'({s_r, s_g, s_b}), 24'hFF0700);
            end
`ifdef CROSSHAIR_EN
            if (es.blank == 1 && (es.hp == SH_A / 2 || es.vp == SV_A / 2))
                chk("crosshair_rgb", int'({s_r, s_g, s_b}), 24'h00FF00);
`endif
            if (d_hs && !hs_prev) begin
                if (hs_per_ok) chk("svga_hs_period", k - hs_rise_k, 1056);
                hs_rise_k = k; hs_rise_ok = 1; hs_per_ok = 1;
            end
            if (!d_hs && hs_prev && hs_rise_ok) chk("svga_hs_width", k - hs_rise_k, 128);
            if (d_blank && !bl_prev) begin
                if (!bl_rise_ok && k > 0 && hs_rise_k == 0) chk("first_blank_rise_k", k, 2);
                bl_rise_k = k; bl_rise_ok = 1;
            end
            if (!d_blank && bl_prev && bl_rise_ok) chk("svga_blank_len", k - bl_rise_k, 800);
            hs_prev = d_hs;
            bl_prev = d_blank;
        end
    end

    // Async reset must clear every output without a clock edge.
    task automatic check_reset_now();
        chk("rst.small_pins", int'({s_read, s_fs, s_hs, s_vs, s_blank, s_syncn}), 0);
        chk("rst.small_pos",  int'({s_hp, s_vp}), 0);
        chk("rst.small_rgb",  int'({s_r, s_g, s_b}), 0);
        chk("rst.svga_pins",  int'({d_read, d_fs, d_hs, d_vs, d_blank, d_syncn}), 0);
        chk("rst.svga_pos",   int'({d_hp, d_vp}), 0);
        chk("rst.svga_rgb",   int'({d_r, d_g, d_b}), 0);
    endtask

    initial begin
        RESET_N = 1'b0;
        repeat (3) @(negedge CLK);
        #2 RESET_N = 1'b1;
        repeat (3600) @(posedge CLK);
        // Bring the reduced raster to mid-frame (line 7, pixel 4) before resetting.
        for (int i = 0; i < 600 && (k % 504) != 200; i++) @(posedge CLK);
        chk("pre_reset_midframe", k % 504, 200);
        #3 RESET_N = 1'b0;
        #1 check_reset_now();
        repeat (3) @(negedge CLK);
        #2 RESET_N = 1'b1;
        repeat (1500) @(posedge CLK);
        @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
